// File: rtl/uart_echo_ctrl_if.sv
// ============================================================================
// Module      : uart_echo_ctrl_if
// Description : Parallel handshake bundle between the echo controller and the
//               UART receiver/transmitter pair.
//               master modport : echo controller side
//               slave  modport : UART (receiver + transmitter) side
//   rx_done    1  receiver -> ctrl   one-cycle pulse, rx_data valid
//   rx_data    8  receiver -> ctrl   received byte
//   rx_en_sig  1  ctrl -> receiver   high = accept new frames
//   tx_done    1  transmitter -> ctrl  one-cycle pulse, frame sent
//   tx_en_sig  1  ctrl -> transmitter  request, held until tx_done
//   tx_data    8  ctrl -> transmitter  byte to send
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_echo_ctrl_if;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       rx_en_sig;
    logic       tx_done;
    logic       tx_en_sig;
    logic [7:0] tx_data;

    modport master (
        input  rx_done,
        input  rx_data,
        output rx_en_sig,
        input  tx_done,
        output tx_en_sig,
        output tx_data
    );

    modport slave (
        output rx_done,
        output rx_data,
        input  rx_en_sig,
        output tx_done,
        input  tx_en_sig,
        input  tx_data
    );
endinterface

`default_nettype wire

// File: rtl/uart_echo_ctrl.sv
// ============================================================================
// Module      : uart_echo_ctrl
// Description : Loopback responder for a UART tx/rx pair. Received bytes are
//               buffered in a 2**DEPTH_LOG2 x 8 FIFO and returned to the
//               transmitter in arrival order, one request per byte, with a
//               one-cycle gap after every completed frame.
// Ports       : clk         system clock (rising edge)
//               rst_n       asynchronous active-low reset
//               uart_io     handshake bundle (master modport)
//               fifo_cnt_o  current FIFO occupancy (0..2**DEPTH_LOG2)
//               ovf_o       sticky: a received byte was dropped (FIFO full)
//               echo_cnt_o  bytes echoed since reset, wraps to 0
// Options     : UART_ECHO_UPCASE_EN - when defined, bytes 8'h61..8'h7A are
//               converted to upper case as they leave the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_echo_ctrl #(
    parameter int DEPTH_LOG2 = 3,
    parameter int CNT_W      = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    uart_echo_ctrl_if.master           uart_io,
    output logic [DEPTH_LOG2:0]        fifo_cnt_o,
    output logic                       ovf_o,
    output logic [CNT_W-1:0]           echo_cnt_o
);

    localparam int unsigned           C_DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   C_FULL    = (DEPTH_LOG2+1)'(C_DEPTH);
    localparam logic [DEPTH_LOG2:0]   C_CNT_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [CNT_W-1:0]      C_ECHO_ONE = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [7:0]            mem_q [C_DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   cnt_q;
    logic [DEPTH_LOG2:0]   cnt_d;
    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic                  rx_en_q;
    logic                  ovf_q;
    logic [7:0]            tx_data_q;
    logic [CNT_W-1:0]      echo_q;

    logic                  w_full;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_pop;
    logic                  w_ack;
    logic [7:0]            w_head;
    logic [7:0]            w_tx_byte;

    // Full/empty decisions use the count before the edge, so a push into a
    // full FIFO is dropped even if the FSM pops in the same cycle.
    assign w_full = (cnt_q == C_FULL);
    assign w_push = uart_io.rx_done && !w_full;
    assign w_drop = uart_io.rx_done && w_full;
    assign w_pop  = (state_q == S_IDLE) && (cnt_q != '0);
    assign w_ack  = (state_q == S_SEND) && uart_io.tx_done;
    assign w_head = mem_q[rd_ptr_q];

`ifdef UART_ECHO_UPCASE_EN
    assign w_tx_byte = ((w_head >= 8'h61) && (w_head <= 8'h7A)) ? (w_head - 8'h20) : w_head;
`else
    assign w_tx_byte = w_head;
`endif

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed: contents are qualified by cnt_q)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= uart_io.rx_data;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + C_CNT_ONE;
            2'b01:   cnt_d = cnt_q - C_CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rx_en_q   <= 1'b0;
            ovf_q     <= 1'b0;
            tx_data_q <= 8'h00;
            echo_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            // Registered from the next count so rx_en_sig tracks fifo_cnt.
            rx_en_q <= (cnt_d != C_FULL);
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
            end
            if (w_drop) begin
                ovf_q <= 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q  <= rd_ptr_q + C_PTR_ONE;
                tx_data_q <= w_tx_byte;
            end
            if (w_ack) begin
                echo_q <= echo_q + C_ECHO_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_pop) state_d = S_SEND;
            S_SEND:  if (uart_io.tx_done) state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The request is a pure decode of the state register, so it is glitch
    // free and rises exactly one edge after the pop decision.
    always_comb begin
        uart_io.tx_en_sig = (state_q == S_SEND);
        uart_io.tx_data   = tx_data_q;
        uart_io.rx_en_sig = rx_en_q;
    end

    assign fifo_cnt_o = cnt_q;
    assign ovf_o      = ovf_q;
    assign echo_cnt_o = echo_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_echo_ctrl.sv
// ============================================================================
// Module      : tb_uart_echo_ctrl
// Description : Self-checking bench for uart_echo_ctrl. A behavioural model
//               (queue-based FIFO plus a transmitter-phase tracker) predicts
//               every output; echoed bytes are pushed into a scoreboard and
//               checked by an independent monitor when a request rises.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_echo_ctrl;

    localparam int DL    = 3;
    localparam int DEPTH = 1 << DL;
    localparam int CW    = 16;

    logic          clk;
    logic          rst_n;
    logic [DL:0]   fifo_cnt;
    logic          ovf;
    logic [CW-1:0] echo_cnt;

    uart_echo_ctrl_if bus ();

    uart_echo_ctrl #(.DEPTH_LOG2(DL), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_io    (bus.master),
        .fifo_cnt_o (fifo_cnt),
        .ovf_o      (ovf),
        .echo_cnt_o (echo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] xform(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    // ---------------- reference model ----------------
    logic [7:0]    m_fifo[$];
    logic [7:0]    sb_q[$];
    int            m_phase;        // 0 idle, 1 sending, 2 gap
    logic          m_ovf;
    logic [CW-1:0] m_echo;
    logic          m_rx_en;
    logic [7:0]    m_tx_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fifo.delete();
            sb_q.delete();
            m_phase   = 0;
            m_ovf     = 1'b0;
            m_echo    = '0;
            m_rx_en   = 1'b0;
            m_tx_data = 8'h00;
        end else begin
            automatic bit was_full = (m_fifo.size() == DEPTH);
            automatic bit start    = (m_phase == 0) && (m_fifo.size() > 0);
            if (m_phase == 1) begin
                if (bus.tx_done) begin
                    m_phase = 2;
                    m_echo  = m_echo + 1'b1;
                end
            end else if (m_phase == 2) begin
                m_phase = 0;
            end else if (start) begin
                m_phase   = 1;
                m_tx_data = xform(m_fifo.pop_front());
                sb_q.push_back(m_tx_data);
            end
            if (bus.rx_done) begin
                if (was_full) m_ovf = 1'b1;
                else          m_fifo.push_back(bus.rx_data);
            end
            m_rx_en = (m_fifo.size() < DEPTH);
        end
    end

    // ---------------- monitor ----------------
    logic prev_tx_en;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_tx_en = 1'b0;
        end else begin
            chk("fifo_cnt", 32'(fifo_cnt), 32'(m_fifo.size()));
            chk("ovf", 32'(ovf), 32'(m_ovf));
            chk("echo_cnt", 32'(echo_cnt), 32'(m_echo));
            chk("rx_en_sig", 32'(bus.rx_en_sig), 32'(m_rx_en));
            chk("tx_en_sig", 32'(bus.tx_en_sig), 32'(m_phase == 1));
            chk("tx_data_hold", 32'(bus.tx_data), 32'(m_tx_data));
            if (bus.tx_en_sig && !prev_tx_en) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_echo", 32'(bus.tx_data), 32'hFFFF_FFFF);
                end else begin
                    chk("sb_echo_byte", 32'(bus.tx_data), 32'(sb_q.pop_front()));
                end
            end
            prev_tx_en = bus.tx_en_sig;
        end
    end

    // ---------------- stimulus ----------------
    bit auto_tx = 1'b0;
    bit spur    = 1'b0;

    task automatic step(input bit rd, input logic [7:0] d, input bit td);
        @(negedge clk);
        bus.rx_done = rd;
        bus.rx_data = d;
        bus.tx_done = td
                    | (auto_tx && bus.tx_en_sig && ($urandom_range(0, 2) == 0))
                    | (spur && ($urandom_range(0, 7) == 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain(input int bound);
        bit done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (sb_q.size() == 0 && !bus.tx_en_sig && fifo_cnt == 0) begin
                done = 1'b1;
                break;
            end
            step(1'b0, 8'h00, 1'b0);
        end
        chk("drain_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        bus.tx_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_en", 32'(bus.tx_en_sig), 32'd0);
        chk("rst_rx_en", 32'(bus.rx_en_sig), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_echo_cnt", 32'(echo_cnt), 32'd0);
        rst_n = 1'b1;

        // single byte: request appears two edges after the push edge
        idle(2);
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("t1_tx_en_after_1", 32'(bus.tx_en_sig), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        chk("t1_tx_en_after_2", 32'(bus.tx_en_sig), 32'd1);
        chk("t1_tx_data", 32'(bus.tx_data), 32'h55);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("t1_tx_en_low", 32'(bus.tx_en_sig), 32'd0);
        chk("t1_echo_cnt", 32'(echo_cnt), 32'd1);
        idle(2);

        // ordering with tx_done withheld, then released
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        idle(3);
        chk("t2_fifo_cnt", 32'(fifo_cnt), 32'd2);
        auto_tx = 1'b1;
        drain(200);
        auto_tx = 1'b0;

        // overflow: one byte occupies the transmitter, then 9 pushes
        step(1'b1, 8'hA0, 1'b0);
        idle(2);
        for (int i = 1; i <= 9; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("t3_fifo_cnt", 32'(fifo_cnt), 32'd8);
        chk("t3_rx_en", 32'(bus.rx_en_sig), 32'd0);
        chk("t3_ovf", 32'(ovf), 32'd1);
        auto_tx = 1'b1;
        drain(300);
        auto_tx = 1'b0;

        // push in the same cycle as the IDLE pop with two bytes queued
        step(1'b1, 8'h10, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h12, 1'b0);
        idle(2);
        chk("t4_pre_cnt", 32'(fifo_cnt), 32'd2);
        step(1'b0, 8'h00, 1'b1);   // SEND -> GAP
        step(1'b0, 8'h00, 1'b0);   // GAP -> IDLE
        step(1'b1, 8'h13, 1'b0);   // IDLE pop + push
        step(1'b0, 8'h00, 1'b0);
        chk("t4_fifo_cnt", 32'(fifo_cnt), 32'd2);
        chk("t4_tx_en", 32'(bus.tx_en_sig), 32'd1);

        // asynchronous reset while a request is outstanding
        #2 rst_n = 1'b0;
        #1;
        chk("t5_tx_en", 32'(bus.tx_en_sig), 32'd0);
        chk("t5_rx_en", 32'(bus.rx_en_sig), 32'd0);
        chk("t5_tx_data", 32'(bus.tx_data), 32'd0);
        chk("t5_fifo_cnt", 32'(fifo_cnt), 32'd0);
        chk("t5_ovf", 32'(ovf), 32'd0);
        chk("t5_echo_cnt", 32'(echo_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        auto_tx = 1'b1;
        idle(6);
        chk("t5_no_echo", 32'(bus.tx_en_sig), 32'd0);

        // case conversion option
        step(1'b1, 8'h61, 1'b0);
        step(1'b1, 8'h7B, 1'b0);
        drain(200);

        // randomized traffic
        spur = 1'b1;
        for (int blk = 0; blk < 6; blk++) begin
            automatic int pct = $urandom_range(5, 80);
            auto_tx = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 400; i++) begin
                automatic logic [7:0] d = ($urandom_range(0, 1) == 0)
                                        ? 8'($urandom_range(8'h5E, 8'h7D))
                                        : 8'($urandom);
                step($urandom_range(0, 99) < pct, d, 1'b0);
            end
        end
        spur = 1'b0;
        auto_tx = 1'b1;
        drain(500);
        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
